// File: rtl/knn_vote.sv
// Majority vote over the K nearest neighbours: label lookup, sequential per-class
// counting, then a class scan with nearest-neighbour tie-break.
module knn_vote #(
  parameter int unsigned IDX_W       = 7,
  parameter int unsigned NUM_PTS     = 128,
  parameter int unsigned LABEL_W     = 4,
  parameter int unsigned NUM_CLASSES = 16,
  parameter int unsigned K           = 6,
  parameter int unsigned CNT_W       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               LBL_WE,
  input  logic [IDX_W-1:0]   LBL_ADDR,
  input  logic [LABEL_W-1:0] LBL_WDATA,
  input  logic               VOTE_START,
  input  logic [2:0]         VOTE_K,
  input  logic [IDX_W-1:0]   IN1,
  input  logic [IDX_W-1:0]   IN2,
  input  logic [IDX_W-1:0]   IN3,
  input  logic [IDX_W-1:0]   IN4,
  input  logic [IDX_W-1:0]   IN5,
  input  logic [IDX_W-1:0]   IN6,
  output logic               VOTE_BUSY,
  output logic               VOTE_DONE,
  output logic [LABEL_W-1:0] VOTE_CLASS,
  output logic [CNT_W-1:0]   VOTE_COUNT,
  output logic               VOTE_TIE
);

  localparam int unsigned NUM_IN = 6;
  localparam int unsigned RANK_W = 3;
  localparam int unsigned CLS_W  = LABEL_W;

  typedef enum logic [1:0] {IDLE, COUNT, SELECT, DONE} state_e;

  state_e state_q, state_d;

  logic [LABEL_W-1:0] lbl_q   [NUM_PTS];
  logic [LABEL_W-1:0] lbl_d   [NUM_PTS];
  logic [IDX_W-1:0]   idx_q   [NUM_IN];
  logic [IDX_W-1:0]   idx_d   [NUM_IN];
  logic [CNT_W-1:0]   cnt_q   [NUM_CLASSES];
  logic [CNT_W-1:0]   cnt_d   [NUM_CLASSES];
  logic [RANK_W-1:0]  first_q [NUM_CLASSES];
  logic [RANK_W-1:0]  first_d [NUM_CLASSES];

  logic [RANK_W-1:0]  keff_q, keff_d, rank_q, rank_d, best_first_q, best_first_d;
  logic [CLS_W-1:0]   cls_q, cls_d, best_class_q, best_class_d;
  logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
  logic               best_tie_q, best_tie_d;
  logic               busy_q, busy_d, done_q, done_d, tie_q, tie_d;
  logic [LABEL_W-1:0] class_q, class_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [IDX_W-1:0]   in_c [NUM_IN];
  logic [RANK_W-1:0]  keff_c;
  logic [IDX_W-1:0]   cur_idx_c;
  logic [LABEL_W-1:0] cur_lbl_c;

  assign in_c[0] = IN1;
  assign in_c[1] = IN2;
  assign in_c[2] = IN3;
  assign in_c[3] = IN4;
  assign in_c[4] = IN5;
  assign in_c[5] = IN6;

  assign keff_c = (VOTE_K == RANK_W'(0)) ? RANK_W'(1) :
                  (VOTE_K > RANK_W'(K))  ? RANK_W'(K) : VOTE_K;

  // Label of the neighbour at the current rank; out-of-table indices read as 0
  always_comb begin
    cur_idx_c = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (rank_q == RANK_W'(i)) cur_idx_c = idx_q[i];
    end
    cur_lbl_c = (32'(cur_idx_c) < NUM_PTS) ? lbl_q[cur_idx_c] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (VOTE_START) state_d = COUNT;
      COUNT:   if (rank_q == keff_q - RANK_W'(1)) state_d = SELECT;
      SELECT:  if (cls_q == CLS_W'(NUM_CLASSES - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lbl_d        = lbl_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    keff_d       = keff_q;
    rank_d       = rank_q;
    cls_d        = cls_q;
    best_first_d = best_first_q;
    best_class_d = best_class_q;
    best_cnt_d   = best_cnt_q;
    best_tie_d   = best_tie_q;
    class_d      = class_q;
    count_d      = count_q;
    tie_d        = tie_q;
    done_d       = 1'b0;
    busy_d       = (state_d != IDLE);

    if (LBL_WE && (32'(LBL_ADDR) < NUM_PTS)) lbl_d[LBL_ADDR] = LBL_WDATA;

    case (state_q)
      IDLE: begin
        if (VOTE_START) begin
          idx_d  = in_c;
          keff_d = keff_c;
          rank_d = '0;
          for (int c = 0; c < int'(NUM_CLASSES); c++) begin
            cnt_d[c]   = '0;
            first_d[c] = '0;
          end
        end
      end
      COUNT: begin
        if (32'(cur_lbl_c) < NUM_CLASSES) begin
          if (cnt_q[cur_lbl_c] == '0) first_d[cur_lbl_c] = rank_q;
          cnt_d[cur_lbl_c] = cnt_q[cur_lbl_c] + CNT_W'(1);
        end
        rank_d = rank_q + RANK_W'(1);
        if (state_d == SELECT) begin
          cls_d        = '0;
          best_class_d = '0;
          best_cnt_d   = '0;
          best_first_d = '1;
          best_tie_d   = 1'b0;
        end
      end
      SELECT: begin
        // Higher count wins outright; equal nonzero count flags a tie and nearer first vote wins
        if (cnt_q[cls_q] > best_cnt_q) begin
          best_class_d = cls_q;
          best_cnt_d   = cnt_q[cls_q];
          best_first_d = first_q[cls_q];
          best_tie_d   = 1'b0;
        end else if (cnt_q[cls_q] == best_cnt_q && cnt_q[cls_q] != '0) begin
          best_tie_d = 1'b1;
          if (first_q[cls_q] < best_first_q) begin
            best_class_d = cls_q;
            best_first_d = first_q[cls_q];
          end
        end
        cls_d = cls_q + CLS_W'(1);
      end
      DONE: begin
        class_d = best_class_q;
        count_d = best_cnt_q;
        tie_d   = best_tie_q;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_PTS); i++) lbl_q[i] <= '0;
      for (int i = 0; i < int'(NUM_IN); i++) idx_q[i] <= '0;
      for (int c = 0; c < int'(NUM_CLASSES); c++) begin
        cnt_q[c]   <= '0;
        first_q[c] <= '0;
      end
      keff_q       <= '0;
      rank_q       <= '0;
      cls_q        <= '0;
      best_first_q <= '0;
      best_class_q <= '0;
      best_cnt_q   <= '0;
      best_tie_q   <= 1'b0;
      class_q      <= '0;
      count_q      <= '0;
      tie_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      lbl_q        <= lbl_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      keff_q       <= keff_d;
      rank_q       <= rank_d;
      cls_q        <= cls_d;
      best_first_q <= best_first_d;
      best_class_q <= best_class_d;
      best_cnt_q   <= best_cnt_d;
      best_tie_q   <= best_tie_d;
      class_q      <= class_d;
      count_q      <= count_d;
      tie_q        <= tie_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign VOTE_BUSY  = busy_q;
  assign VOTE_DONE  = done_q;
  assign VOTE_CLASS = class_q;
  assign VOTE_COUNT = count_q;
  assign VOTE_TIE   = tie_q;

endmodule
